// File: rtl/cmd_issue_timer.sv
// DRAM command issue stage: pops commands from the issue FIFO once the per-bank and
// global timing constraints allow it, and drops illegal or NOP commands in a single cycle.
`timescale 1ns/1ps
module cmd_issue_timer #(
    parameter int T_RCD = 3,
    parameter int T_RP  = 3,
    parameter int T_RAS = 7,
    parameter int T_CCD = 2,
    parameter int T_RFC = 16,
    parameter int TW    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [20:0] fifo_data,
    output logic        fifo_ren,
    output logic [3:0]  dram_cmd,
    output logic [13:0] dram_addr,
    output logic [2:0]  dram_bank,
    output logic        dram_valid,
    output logic [7:0]  bank_open,
    output logic        err
);

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_ACT = 4'b0001,
        CMD_RD  = 4'b0010,
        CMD_WR  = 4'b0011,
        CMD_PRE = 4'b0100,
        CMD_REF = 4'b0101
    } cmd_e;

    typedef logic [TW-1:0] tmr_t;

    tmr_t        rcd_q [8], rcd_d [8];
    tmr_t        ras_q [8], ras_d [8];
    tmr_t        rp_q  [8], rp_d  [8];
    tmr_t        ccd_q, ccd_d;
    tmr_t        rfc_q, rfc_d;
    logic [7:0]  bank_open_q, bank_open_d;
    logic [3:0]  dram_cmd_q;
    logic [13:0] dram_addr_q;
    logic [2:0]  dram_bank_q;
    logic        dram_valid_q;
    logic        err_q;

    cmd_e        head_cmd;
    logic [13:0] head_addr;
    logic [2:0]  head_bank;
    logic        is_nop;
    logic        bad_cmd;
    logic        timers_ok;
    logic        rp_all_zero;
    logic        pop;
    logic        issue;

    function automatic tmr_t dec_sat(input tmr_t v);
        return (v == '0) ? v : v - tmr_t'(1);
    endfunction

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        head_cmd    = cmd_e'(fifo_data[20:17]);
        head_addr   = fifo_data[16:3];
        head_bank   = fifo_data[2:0];
        is_nop      = 1'b0;
        bad_cmd     = 1'b0;
        timers_ok   = 1'b0;
        rp_all_zero = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (rp_q[b] != '0) rp_all_zero = 1'b0;
        end

        // Illegal codes and bank-state violations are dropped regardless of timers.
        case (head_cmd)
            CMD_NOP: is_nop = 1'b1;
            CMD_ACT: begin
                bad_cmd   = bank_open_q[head_bank];
                timers_ok = (rp_q[head_bank] == '0);
            end
            CMD_RD, CMD_WR: begin
                bad_cmd   = !bank_open_q[head_bank];
                timers_ok = (rcd_q[head_bank] == '0) && (ccd_q == '0);
            end
            CMD_PRE: begin
                bad_cmd   = !bank_open_q[head_bank];
                timers_ok = (ras_q[head_bank] == '0);
            end
            CMD_REF: begin
                bad_cmd   = (bank_open_q != '0);
                timers_ok = rp_all_zero;
            end
            default: bad_cmd = 1'b1;
        endcase
        if (rfc_q != '0) timers_ok = 1'b0;

        pop   = !rst && !fifo_empty && (is_nop || bad_cmd || timers_ok);
        issue = pop && !is_nop && !bad_cmd;
    end

    // Next-state for timers and open flags: a load on issue overrides the decrement.
    always_comb begin
        ccd_d       = dec_sat(ccd_q);
        rfc_d       = dec_sat(rfc_q);
        bank_open_d = bank_open_q;
        for (int b = 0; b < 8; b++) begin
            rcd_d[b] = dec_sat(rcd_q[b]);
            ras_d[b] = dec_sat(ras_q[b]);
            rp_d[b]  = dec_sat(rp_q[b]);
        end
        if (issue) begin
            case (head_cmd)
                CMD_ACT: begin
                    rcd_d[head_bank]       = tmr_t'(T_RCD - 1);
                    ras_d[head_bank]       = tmr_t'(T_RAS - 1);
                    bank_open_d[head_bank] = 1'b1;
                end
                CMD_PRE: begin
                    rp_d[head_bank]        = tmr_t'(T_RP - 1);
                    bank_open_d[head_bank] = 1'b0;
                end
                CMD_RD, CMD_WR: ccd_d = tmr_t'(T_CCD - 1);
                CMD_REF:        rfc_d = tmr_t'(T_RFC - 1);
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; the timer arrays are reset explicitly because stale timing would
    // otherwise block the first command after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 8; b++) begin
                rcd_q[b] <= '0;
                ras_q[b] <= '0;
                rp_q[b]  <= '0;
            end
            ccd_q        <= '0;
            rfc_q        <= '0;
            bank_open_q  <= '0;
            dram_cmd_q   <= '0;
            dram_addr_q  <= '0;
            dram_bank_q  <= '0;
            dram_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int b = 0; b < 8; b++) begin
                rcd_q[b] <= rcd_d[b];
                ras_q[b] <= ras_d[b];
                rp_q[b]  <= rp_d[b];
            end
            ccd_q        <= ccd_d;
            rfc_q        <= rfc_d;
            bank_open_q  <= bank_open_d;
            dram_valid_q <= issue;
            err_q        <= pop && bad_cmd;
            if (issue) begin
                dram_cmd_q  <= head_cmd;
                dram_addr_q <= head_addr;
                dram_bank_q <= head_bank;
            end
        end
    end

    assign fifo_ren   = pop;
    assign dram_cmd   = dram_cmd_q;
    assign dram_addr  = dram_addr_q;
    assign dram_bank  = dram_bank_q;
    assign dram_valid = dram_valid_q;
    assign bank_open  = bank_open_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cmd_issue_timer.sv
// Bench for cmd_issue_timer: a FIFO queue plus an earliest-allowed-cycle model of the
// DRAM timing rules, compared against the DUT every cycle, with directed timing scenarios.
`timescale 1ns/1ps
module tb_cmd_issue_timer;
    localparam int T_RCD = 3;
    localparam int T_RP  = 3;
    localparam int T_RAS = 7;
    localparam int T_CCD = 2;
    localparam int T_RFC = 16;

    localparam logic [3:0] C_NOP = 4'd0;
    localparam logic [3:0] C_ACT = 4'd1;
    localparam logic [3:0] C_RD  = 4'd2;
    localparam logic [3:0] C_WR  = 4'd3;
    localparam logic [3:0] C_PRE = 4'd4;
    localparam logic [3:0] C_REF = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [20:0] fifo_data = '0;
    logic        fifo_ren;
    logic [3:0]  dram_cmd;
    logic [13:0] dram_addr;
    logic [2:0]  dram_bank;
    logic        dram_valid;
    logic [7:0]  bank_open;
    logic        err;

    cmd_issue_timer #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CCD(T_CCD), .T_RFC(T_RFC), .TW(5)
    ) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_ren(fifo_ren), .dram_cmd(dram_cmd), .dram_addr(dram_addr),
        .dram_bank(dram_bank), .dram_valid(dram_valid), .bank_open(bank_open), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [2:0] bank;
        bit         dropped;
    } pop_t;

    logic [20:0] fq[$];
    pop_t        plog[$];

    // Model: earliest cycle in which each kind of command may pop.
    logic [7:0]  m_open;
    int          act_ok[8], rdwr_ok[8], pre_ok[8];
    int          ccd_ok, rfc_ok;
    logic        m_valid, m_err;
    logic [3:0]  m_cmd;
    logic [13:0] m_addr;
    logic [2:0]  m_bank;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_open = '0;
        for (int i = 0; i < 8; i++) begin
            act_ok[i] = 0; rdwr_ok[i] = 0; pre_ok[i] = 0;
        end
        ccd_ok = 0; rfc_ok = 0;
        m_valid = 0; m_err = 0; m_cmd = '0; m_addr = '0; m_bank = '0;
    endfunction

    function automatic void model_decide(input logic [20:0] h, output bit pop, output bit drop);
        logic [3:0] c;
        int         b;
        bit         free;
        c = h[20:17];
        b = int'(h[2:0]);
        free = (cyc >= rfc_ok);
        pop = 0;
        drop = 0;
        case (c)
            C_NOP: pop = 1;
            C_ACT: if (m_open[b]) drop = 1; else pop = free && cyc >= act_ok[b];
            C_RD, C_WR: if (!m_open[b]) drop = 1;
                        else pop = free && cyc >= rdwr_ok[b] && cyc >= ccd_ok;
            C_PRE: if (!m_open[b]) drop = 1; else pop = free && cyc >= pre_ok[b];
            C_REF: if (m_open != 0) drop = 1;
                   else begin
                       pop = free;
                       for (int i = 0; i < 8; i++) if (cyc < act_ok[i]) pop = 0;
                   end
            default: drop = 1;
        endcase
        if (drop) pop = 1;
    endfunction

    task automatic cycle();
        bit          pop, drop;
        logic [20:0] h;
        pop_t        e;
        int          b;
        @(negedge clk);
        fifo_empty = (fq.size() == 0);
        h = fifo_empty ? 21'($urandom) : fq[0];
        fifo_data = h;
        #1;
        pop = 0;
        drop = 0;
        if (!rst && !fifo_empty) model_decide(h, pop, drop);
        check("fifo_ren", 32'(fifo_ren), 32'(pop));
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            m_valid = 0;
            m_err = 0;
            if (pop) begin
                h = fq.pop_front();
                e.cyc = cyc; e.cmd = h[20:17]; e.bank = h[2:0]; e.dropped = drop;
                plog.push_back(e);
                b = int'(h[2:0]);
                if (drop) m_err = 1;
                else if (h[20:17] != C_NOP) begin
                    m_valid = 1; m_cmd = h[20:17]; m_addr = h[16:3]; m_bank = h[2:0];
                    case (h[20:17])
                        C_ACT: begin
                            m_open[b] = 1; rdwr_ok[b] = cyc + T_RCD; pre_ok[b] = cyc + T_RAS;
                        end
                        C_PRE: begin m_open[b] = 0; act_ok[b] = cyc + T_RP; end
                        C_RD, C_WR: ccd_ok = cyc + T_CCD;
                        C_REF: rfc_ok = cyc + T_RFC;
                        default: ;
                    endcase
                end
            end
        end
        cyc++;
        check("dram_valid", 32'(dram_valid), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
        check("bank_open", 32'(bank_open), 32'(m_open));
        check("dram_cmd", 32'(dram_cmd), 32'(m_cmd));
        check("dram_addr", 32'(dram_addr), 32'(m_addr));
        check("dram_bank", 32'(dram_bank), 32'(m_bank));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        fq.delete();
        rst = 1;
        run(2);
        rst = 0;
    endtask

    function automatic logic [20:0] mk(input logic [3:0] c, input logic [13:0] a, input logic [2:0] b);
        return {c, a, b};
    endfunction

    function automatic int pop_at(input int i);
        return (i < plog.size()) ? plog[i].cyc : -1000;
    endfunction

    function automatic logic [20:0] rand_cmd();
        int          r;
        logic [3:0]  c;
        r = $urandom_range(0, 19);
        if (r < 5) c = C_ACT;
        else if (r < 10) c = C_RD;
        else if (r < 12) c = C_WR;
        else if (r < 15) c = C_PRE;
        else if (r < 16) c = C_REF;
        else if (r < 17) c = C_NOP;
        else c = 4'($urandom_range(6, 15));
        return mk(c, 14'($urandom), 3'($urandom_range(0, 3)));
    endfunction

    initial begin
        int r_cyc;
        model_reset();
        do_reset();
        check("reset_valid", 32'(dram_valid), 32'd0);
        check("reset_open", 32'(bank_open), 32'd0);

        // ACT b2 then RD b2: RD three cycles later, bank 2 open right after the ACT.
        plog.delete();
        fq.push_back(mk(C_ACT, 14'h0123, 3'd2));
        fq.push_back(mk(C_RD, 14'h0010, 3'd2));
        cycle();
        check("s1_open", 32'(bank_open), 32'h04);
        check("s1_act_addr", 32'(dram_addr), 32'h0123);
        run(5);
        check("s1_rd_gap", 32'(pop_at(1) - pop_at(0)), 32'd3);

        // Two reads to different open banks issue tCCD apart.
        do_reset();
        fq.push_back(mk(C_ACT, 14'h0001, 3'd2));
        fq.push_back(mk(C_ACT, 14'h0002, 3'd5));
        run(8);
        plog.delete();
        fq.push_back(mk(C_RD, 14'h0020, 3'd2));
        fq.push_back(mk(C_RD, 14'h0030, 3'd5));
        run(5);
        check("s2_rd_gap", 32'(pop_at(1) - pop_at(0)), 32'd2);

        // ACT / PRE / ACT on bank 0: tRAS then tRP.
        do_reset();
        plog.delete();
        fq.push_back(mk(C_ACT, 14'h0100, 3'd0));
        fq.push_back(mk(C_PRE, 14'h0000, 3'd0));
        fq.push_back(mk(C_ACT, 14'h0200, 3'd0));
        run(14);
        check("s3_pre_gap", 32'(pop_at(1) - pop_at(0)), 32'd7);
        check("s3_act_gap", 32'(pop_at(2) - pop_at(0)), 32'd10);

        // Read to a closed bank is dropped with a one-cycle err.
        do_reset();
        fq.push_back(mk(C_RD, 14'h0040, 3'd3));
        cycle();
        check("s4_err", 32'(err), 32'd1);
        check("s4_valid", 32'(dram_valid), 32'd0);
        check("s4_open", 32'(bank_open), 32'd0);
        cycle();
        check("s4_err_clear", 32'(err), 32'd0);

        // REF holds off the next ACT for tRFC; REF with a bank open is an error.
        do_reset();
        plog.delete();
        fq.push_back(mk(C_REF, 14'h0000, 3'd0));
        fq.push_back(mk(C_ACT, 14'h0055, 3'd1));
        run(20);
        check("s5_ref_gap", 32'(pop_at(1) - pop_at(0)), 32'd16);
        fq.push_back(mk(C_REF, 14'h0000, 3'd0));
        cycle();
        check("s5_ref_err", 32'(err), 32'd1);
        check("s5_ref_open", 32'(bank_open), 32'h02);

        // Reset mid-tRCD clears open state; ACT b2 issues right after release.
        do_reset();
        fq.push_back(mk(C_ACT, 14'h0123, 3'd2));
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        check("s6_open_cleared", 32'(bank_open), 32'd0);
        plog.delete();
        r_cyc = cyc;
        fq.push_back(mk(C_ACT, 14'h0123, 3'd2));
        cycle();
        check("s6_act_immediate", 32'(pop_at(0)), 32'(r_cyc));
        check("s6_open", 32'(bank_open), 32'h04);

        // Randomized traffic, occasional reset and empty FIFO.
        do_reset();
        plog.delete();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (fq.size() < 3 && $urandom_range(0, 1) == 1) fq.push_back(rand_cmd());
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_issue_timer.md
CMD_ISSUE_TIMER -- requirements
Module: cmd_issue_timer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be one per line:
  T_RCD 3 ACT-to-RD/WR cycles, same bank
  T_RP 3 PRE-to-ACT cycles, same bank
  T_RAS 7 ACT-to-PRE cycles, same bank
  T_CCD 2 RD/WR-to-RD/WR cycles, any bank
  T_RFC 16 REF-to-any-command cycles
  TW 5 timer counter width
REQ-002 Ports (name, direction, width, meaning) SHALL be one per line:
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  synchronous reset, active-high
  fifo_empty  in  1  issue FIFO empty flag
  fifo_data  in  21  FIFO head {cmd[20:17], addr[16:3], bank[2:0]}
  fifo_ren  out  1  combinational pop strobe to issue FIFO
  dram_cmd  out  4  registered DRAM command
  dram_addr  out  14  registered row/column address
  dram_bank  out  3  registered bank
  dram_valid  out  1  registered command-valid strobe
  bank_open  out  8  registered per-bank row-open flags
  err  out  1  registered one-cycle illegal-command pulse

Function
REQ-003 Command encodings SHALL be NOP=0000, ACT=0001, RD=0010, WR=0011, PRE=0100, REF=0101; all other codes are illegal.
REQ-004 Per-bank down-counters rcd[b], ras[b], rp[b] (TW bits) and global down-counters ccd, rfc SHALL decrement by 1 each cycle and saturate at 0.
REQ-005 The head SHALL be legal when: ACT: bank closed, rp[b]==0; RD/WR: bank open, rcd[b]==0, ccd==0; PRE: bank open, ras[b]==0; REF: bank_open==0, all rp==0; NOP: always. rfc!=0 SHALL make every command except NOP not ready.
REQ-006 fifo_ren SHALL assert in the same cycle as the head when !fifo_empty and the head is one of: NOP, an illegal code, an illegal state (wrong bank-open state for the command), or a legal command whose timers are all 0.
REQ-007 A head blocked only by nonzero timers SHALL hold fifo_ren=0, stall in place, and never be reordered.
REQ-008 A legal non-NOP head popped in cycle n SHALL appear on dram_cmd/addr/bank with dram_valid=1 in cycle n+1; dram_valid SHALL be 0 in every other cycle.
REQ-009 On a pop in cycle n, the timers SHALL load the value T-1 at the n+1 edge: ACT loads rcd[b]=T_RCD-1, ras[b]=T_RAS-1; PRE loads rp[b]=T_RP-1; RD/WR load ccd=T_CCD-1; REF loads rfc=T_RFC-1. The earliest dependent pop is therefore cycle n+T.
REQ-010 bank_open[b] SHALL set on an ACT pop and clear on a PRE pop, effective at cycle n+1.
REQ-011 A head that is an illegal code, or a command illegal for the bank state (ACT to open bank, RD/WR/PRE to closed bank, REF with any bank open), SHALL be popped and dropped; err=1 in cycle n+1; no timer or bank_open change; dram_valid=0.
REQ-012 A NOP SHALL be popped and produce no output, no err, and no state change.
REQ-013 dram_cmd/addr/bank SHALL hold their last values when dram_valid=0.
REQ-014 At most one pop SHALL occur per cycle; fifo_ren SHALL be 0 whenever fifo_empty=1.
REQ-015 Timer loads SHALL take priority over decrement in the same cycle.

Reset
REQ-016 While rst=1, all counters, bank_open, dram_cmd, dram_addr, dram_bank, dram_valid and err SHALL be 0, and fifo_ren SHALL be forced to 0.
REQ-017 rst asserted mid-operation SHALL discard all timing state and open-bank state at the next edge; the first legal pop SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-018 The bench SHALL cover these scenarios:
  ACT b2 row 0x0123 popped at cycle 10, then RD b2 -> RD pops at cycle 13; dram_valid pulses at cycles 11 and 14; bank_open=0x04 from cycle 11.
  Back-to-back RD b2 then RD b5 (both banks open, rcd expired) -> pops 2 cycles apart.
  ACT b0 at cycle 0, PRE b0 queued -> PRE pops at cycle 7; then ACT b0 pops at cycle 10.
  RD to closed bank 3 -> popped, err=1 one cycle, dram_valid=0, bank_open unchanged.
  REF with all banks closed at cycle 20 -> next ACT pops at cycle 36; REF with bank 1 open -> err.
  rst pulse while rcd[2]=2 and bank 2 open -> after release bank_open=0 and ACT b2 pops immediately.
